// File: rtl/pc_sequencer.sv
// Next-PC engine with a hardware return stack for CALL/RET and a single-level
// interrupt entry that pushes the pending next-PC and vectors to IRQ_VEC.
module pc_sequencer #(
    parameter int              PC_W    = 10,
    parameter int              DEPTH   = 8,
    parameter logic [PC_W-1:0] IRQ_VEC = PC_W'('h3F0),
    localparam int             AW      = $clog2(DEPTH),
    localparam int             SP_W    = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            s_inc,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] jump_addr,
    input  logic            irq,
    output logic            irq_ack,
    output logic [PC_W-1:0] pc,
    output logic [SP_W-1:0] sp,
    output logic            stack_full,
    output logic            stack_empty,
    output logic            stack_err,
    output logic            in_isr
);

    localparam logic [SP_W-1:0] SP_DEPTH = SP_W'(DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ,
        OP_ILLEGAL,
        OP_POP,
        OP_PUSH,
        OP_IRQ
    } op_e;

    logic [PC_W-1:0] stack_mem [DEPTH];

    logic [SP_W-1:0] isr_base;
    op_e             op;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] seq_pc;
    logic [SP_W-1:0] sp_dec;
    logic [PC_W-1:0] stack_top;

    logic [PC_W-1:0] pc_n;
    logic [SP_W-1:0] sp_n;
    logic [SP_W-1:0] isr_base_n;
    logic            err_n;
    logic            in_isr_n;
    logic            ack_n;
    logic            stack_we;
    logic [PC_W-1:0] stack_wdata;

    assign stack_full  = (sp == SP_DEPTH);
    assign stack_empty = (sp == '0);

    assign pc_inc    = pc + 1'b1;
    assign seq_pc    = s_inc ? pc_inc : jump_addr;
    assign sp_dec    = sp - 1'b1;
    assign stack_top = stack_mem[sp_dec[AW-1:0]];

    // Interrupt only competes with plain sequencing; CALL/RET or a full stack defers it.
    always_comb begin
        op = OP_SEQ;
        if (push && pop)
            op = OP_ILLEGAL;
        else if (pop)
            op = OP_POP;
        else if (push)
            op = OP_PUSH;
        else if (irq && !in_isr && !stack_full)
            op = OP_IRQ;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        pc_n        = pc;
        sp_n        = sp;
        isr_base_n  = isr_base;
        err_n       = stack_err;
        in_isr_n    = in_isr;
        ack_n       = 1'b0;
        stack_we    = 1'b0;
        stack_wdata = '0;

        if (!stall) begin
            unique case (op)
                OP_ILLEGAL: begin
                    pc_n  = pc_inc;
                    err_n = 1'b1;
                end
                OP_POP: begin
                    if (!stack_empty) begin
                        pc_n = stack_top;
                        sp_n = sp_dec;
                        if (in_isr && (sp_dec == isr_base))
                            in_isr_n = 1'b0;
                    end else begin
                        pc_n  = pc_inc;
                        err_n = 1'b1;
                    end
                end
                OP_PUSH: begin
                    pc_n = jump_addr;
                    if (!stack_full) begin
                        stack_we    = 1'b1;
                        stack_wdata = pc_inc;
                        sp_n        = sp + 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                OP_IRQ: begin
                    stack_we    = 1'b1;
                    stack_wdata = seq_pc;
                    sp_n        = sp + 1'b1;
                    pc_n        = IRQ_VEC;
                    in_isr_n    = 1'b1;
                    isr_base_n  = sp;
                    ack_n       = 1'b1;
                end
                default: begin
                    pc_n = seq_pc;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            sp        <= '0;
            isr_base  <= '0;
            stack_err <= 1'b0;
            in_isr    <= 1'b0;
            irq_ack   <= 1'b0;
        end else begin
            pc        <= pc_n;
            sp        <= sp_n;
            isr_base  <= isr_base_n;
            stack_err <= err_n;
            in_isr    <= in_isr_n;
            irq_ack   <= ack_n;
        end
    end

    // NOTE: the stack RAM has no reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        if (stack_we)
            stack_mem[sp[AW-1:0]] <= stack_wdata;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main sequencing and
// ISR flow, plus hand sequences for errors, async reset and stack overflow.
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       s_inc;
    logic       push;
    logic       pop;
    logic [9:0] jump_addr;
    logic       irq;
    logic       irq_ack;
    logic [9:0] pc;
    logic [3:0] sp;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;
    logic       in_isr;

    int tests = 0;
    int fails = 0;

    pc_sequencer #(
        .PC_W   (10),
        .DEPTH  (8),
        .IRQ_VEC(10'h3F0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .s_inc      (s_inc),
        .push       (push),
        .pop        (pop),
        .jump_addr  (jump_addr),
        .irq        (irq),
        .irq_ack    (irq_ack),
        .pc         (pc),
        .sp         (sp),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err),
        .in_isr     (in_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       st;
        logic       si;
        logic       pu;
        logic       po;
        logic       iq;
        logic [9:0] ja;
        logic [9:0] e_pc;
        logic [3:0] e_sp;
        logic       e_err;
        logic       e_isr;
        logic       e_ack;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic st, si, pu, po, iq, input logic [9:0] ja,
                                input logic [9:0] epc, input logic [3:0] esp,
                                input logic eerr, eisr, eack);
        return '{st, si, pu, po, iq, ja, epc, esp, eerr, eisr, eack};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic st, si, pu, po, iq, input logic [9:0] ja);
        stall     = st;
        s_inc     = si;
        push      = pu;
        pop       = po;
        irq       = iq;
        jump_addr = ja;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [9:0] epc, input logic [3:0] esp,
                               input logic eerr, eisr, eack);
        check({tag, "_pc"}, 32'(pc), 32'(epc));
        check({tag, "_sp"}, 32'(sp), 32'(esp));
        check({tag, "_err"}, 32'(stack_err), 32'(eerr));
        check({tag, "_isr"}, 32'(in_isr), 32'(eisr));
        check({tag, "_ack"}, 32'(irq_ack), 32'(eack));
        check({tag, "_full"}, 32'(stack_full), 32'(esp == 4'd8));
        check({tag, "_empty"}, 32'(stack_empty), 32'(esp == 4'd0));
    endtask

    initial begin
        //                st  si  pu  po  iq  jump     pc      sp  err isr ack
        vecs[0]  = mk(0, 1, 0, 0, 0, 10'h000, 10'h001, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 10'h000, 10'h002, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 10'h000, 10'h003, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 10'h000, 10'h004, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 10'h120, 10'h120, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 10'h3FF, 10'h3FF, 0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 10'h010, 10'h010, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0, 0, 10'h200, 10'h200, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 1, 0, 10'h000, 10'h011, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 10'h040, 10'h040, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 0, 0, 1, 10'h000, 10'h3F0, 1, 0, 1, 1);
        vecs[12] = mk(0, 1, 0, 0, 1, 10'h000, 10'h3F1, 1, 0, 1, 0);
        vecs[13] = mk(0, 0, 1, 0, 0, 10'h300, 10'h300, 2, 0, 1, 0);
        vecs[14] = mk(1, 1, 0, 0, 0, 10'h000, 10'h300, 2, 0, 1, 0);
        vecs[15] = mk(0, 0, 0, 1, 0, 10'h000, 10'h3F2, 1, 0, 1, 0);
        vecs[16] = mk(0, 0, 0, 1, 0, 10'h000, 10'h041, 0, 0, 0, 0);
        vecs[17] = mk(0, 1, 0, 0, 0, 10'h000, 10'h042, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 1, 0, 1, 10'h100, 10'h100, 1, 0, 0, 0);
        vecs[19] = mk(1, 0, 0, 0, 1, 10'h000, 10'h100, 1, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 1, 1, 10'h000, 10'h043, 0, 0, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 1, 10'h080, 10'h3F0, 1, 0, 1, 1);
        vecs[22] = mk(0, 0, 0, 1, 0, 10'h000, 10'h080, 0, 0, 0, 0);

        reset = 1'b1; stall = 1'b0; s_inc = 1'b0; push = 1'b0; pop = 1'b0;
        irq = 1'b0; jump_addr = '0;
        #1;
        check_state("reset", 10'h000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].st, vecs[i].si, vecs[i].pu, vecs[i].po, vecs[i].iq, vecs[i].ja);
            check_state($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_sp,
                        vecs[i].e_err, vecs[i].e_isr, vecs[i].e_ack);
        end

        // Underflow: pop from empty advances pc and latches the error.
        apply(0, 0, 0, 1, 0, 10'h000);
        check_state("underflow", 10'h081, 0, 1, 0, 0);

        // Build pc=0x055, sp=3, in_isr=1, then reset between clock edges.
        apply(0, 1, 0, 0, 1, 10'h000);
        check_state("isr_entry2", 10'h3F0, 1, 1, 1, 1);
        apply(0, 0, 1, 0, 0, 10'h100);
        apply(0, 0, 1, 0, 0, 10'h055);
        check_state("pre_reset", 10'h055, 3, 1, 1, 0);
        stall = 1'b0; s_inc = 1'b0; push = 1'b0; pop = 1'b0; irq = 1'b0; jump_addr = '0;
        #2;
        reset = 1'b1;
        #1;
        check_state("async_reset", 10'h000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill the stack, overflow it, then check deferral and illegal op while full.
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, 1, 0, 0, 10'h200 + 10'(i));
            check($sformatf("fill%0d_sp", i), 32'(sp), 32'(i + 1));
        end
        check_state("full", 10'h207, 8, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 10'h208);
        check_state("overflow", 10'h208, 8, 1, 0, 0);
        apply(0, 1, 0, 0, 1, 10'h000);
        check_state("irq_full", 10'h209, 8, 1, 0, 0);
        apply(0, 0, 1, 1, 0, 10'h000);
        check_state("illegal", 10'h20A, 8, 1, 0, 0);
        apply(0, 0, 0, 1, 0, 10'h000);
        check_state("pop_full", 10'h207, 7, 1, 0, 0);
        apply(0, 0, 0, 1, 0, 10'h000);
        check_state("pop_full2", 10'h206, 6, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Sequential next-PC and hardware return-stack engine for the CPU, driven directly by the control unit's s_inc/push/pop outputs. Holds the program counter and a LIFO of return addresses for CALL/RET. Adds a single-level interrupt entry with a request/acknowledge handshake. Sits between the control unit and instruction memory; pc addresses the program ROM.

Parameters:
PC_W, 10, program counter / jump address width in bits
DEPTH, 8, return-stack entries (power of two, >=2)
IRQ_VEC, 0x3F0, PC loaded on interrupt entry (PC_W bits)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold all state this cycle
s_inc  input  1  1 = sequential fetch, 0 = take jump_addr
push  input  1  CALL: save return address, jump to jump_addr
pop  input  1  RET: load PC from stack top
jump_addr  input  PC_W  jump/call target from the instruction
irq  input  1  level interrupt request
irq_ack  output  1  one-cycle pulse when interrupt is taken
pc  output  PC_W  current program counter
sp  output  log2(DEPTH)+1  stack occupancy, 0..DEPTH
stack_full  output  1  sp == DEPTH
stack_empty  output  1  sp == 0
stack_err  output  1  sticky overflow/underflow/illegal-op flag
in_isr  output  1  interrupt service in progress

Behaviour:
- Reset (async, immediate): pc=0, sp=0, stack_empty=1, stack_full=0, stack_err=0, irq_ack=0, in_isr=0; stack RAM contents don't care.
- stall=1: pc, sp, stack, in_isr, stack_err held; irq_ack=0; irq not sampled.
- Per unstalled cycle, in priority order:
  1. push=1 and pop=1: illegal; pc<=pc+1, stack unchanged, stack_err<=1.
  2. pop=1: if sp>0, pc<=stack[sp-1], sp<=sp-1; else pc<=pc+1, stack_err<=1. s_inc ignored.
  3. push=1: if sp<DEPTH, stack[sp]<=pc+1, sp<=sp+1; else stack_err<=1, stack unchanged. pc<=jump_addr in both cases.
  4. Otherwise pc<=s_inc ? pc+1 : jump_addr.
- Interrupt entry: taken when irq=1, stall=0, in_isr=0, push=0, pop=0, sp<DEPTH. The normal next-PC from rule 4 is pushed instead of loaded; pc<=IRQ_VEC; sp<=sp+1; in_isr<=1; isr_base<=sp (pre-push value); irq_ack=1 for exactly that cycle (registered, visible next cycle together with pc==IRQ_VEC).
- Deferred: irq with push/pop asserted or stack full is not taken; re-evaluated every cycle while irq stays high. No error flagged.
- Interrupt exit: a successful pop whose resulting sp equals isr_base clears in_isr the same edge. Nested CALL/RET inside the ISR don't clear it.
- pc+1 wraps modulo 2^PC_W (max -> 0); wrapped return addresses are stored as-is.
- stack_full/stack_empty are decoded combinationally from registered sp.
- stack_err is cleared only by reset.
- Latency: every change visible on pc one cycle after the deciding edge; no combinational path from inputs to pc.

Test Plan:
- Reset mid-run with pc=0x055, sp=3, in_isr=1 -> all outputs immediately 0 (stack_empty=1), before the next clk edge.
- s_inc=1 for 4 cycles from 0 -> pc 1,2,3,4; s_inc=0, jump_addr=0x120 -> pc=0x120; from pc=0x3FF with s_inc=1 -> pc=0x000.
- At pc=0x010, push, jump_addr=0x200 -> pc=0x200, sp=1; then pop -> pc=0x011, sp=0, stack_err=0.
- Push DEPTH+1 times -> 9th push: sp stays 8, stack_full=1, stack_err=1, pc=jump_addr. From empty, pop -> pc+1, stack_err=1. push=pop=1 -> stack_err=1, sp unchanged.
- At pc=0x040, irq=1 with s_inc=1 -> next cycle pc=0x3F0, irq_ack=1 for one cycle, sp=1, in_isr=1. CALL/RET inside the ISR keep in_isr=1. Final RET -> pc=0x041, in_isr=0.
- irq=1 held while push=1 and stall=1 -> no irq_ack. Taken on the first cycle with stall=0, push=0, pop=0. irq while in_isr=1 -> ignored until exit.
